packet_ram_bytewise: RTL and testbench

- Next-generation packet memory for the BPF VM. Stores a packet written in DATA_WIDTH-bit words and serves BPF loads of 1, 2 or 4 bytes at any byte address, including loads that span two words, in one issue per cycle.
- Returns the loaded value zero-extended to 32 bits in network (big-endian) byte order, with an out-of-bounds flag.
- Tracks packet length in bytes.
- Sits between the packet ingress logic (write side) and the BPF CPU load unit (read side).

---
 rtl/packet_ram_bytewise_if.sv | 33 +++
 rtl/packet_ram_bytewise.sv | 162 ++++++++++++++++
 tb/tb_packet_ram_bytewise.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_ram_bytewise_if.sv
// Packet RAM bus: ingress write side and BPF load side.
// Master drives writes and load issues, slave returns load results.
interface packet_ram_bytewise_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   localparam int BPW = DATA_WIDTH / 8;
   localparam int BAW = ADDR_WIDTH + $clog2(BPW);

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  len_clr;
   logic                  rd_en;
   logic [BAW-1:0]        rd_addr;
   logic [1:0]            rd_size;
   logic [31:0]           rd_data;
   logic                  rd_valid;
   logic                  rd_oob;
   logic [31:0]           len;

   modport master (
      output wr_en, wr_addr, wr_data, len_clr,
      output rd_en, rd_addr, rd_size,
      input  rd_data, rd_valid, rd_oob, len
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, len_clr,
      input  rd_en, rd_addr, rd_size,
      output rd_data, rd_valid, rd_oob, len
   );
endinterface

// File: rtl/packet_ram_bytewise.sv
// Byte-addressable packet memory for BPF loads of 1/2/4 bytes.
// Even/odd word banks let a load spanning two words issue every cycle.
module packet_ram_bytewise #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0
) (
   input  logic                clk,
   input  logic                rst,
   packet_ram_bytewise_if.slave bus
);
   localparam int BPW = DATA_WIDTH / 8;
   localparam int OFW = $clog2(BPW);
   localparam int BAW = ADDR_WIDTH + OFW;
   localparam int HW  = ADDR_WIDTH - 1;
   localparam int HD  = 2 ** HW;
   localparam logic [32:0] TOP = 33'(1) << BAW;

   logic [DATA_WIDTH-1:0] r_even [HD];
   logic [DATA_WIDTH-1:0] r_odd  [HD];
   logic [DATA_WIDTH-1:0] r_ev_q;
   logic [DATA_WIDTH-1:0] r_od_q;

   logic [ADDR_WIDTH-1:0] w_word;
   logic [OFW-1:0]        w_off;
   logic [HW-1:0]         w_half;
   logic [HW-1:0]         w_ev_addr;
   logic [HW-1:0]         w_wr_half;
   logic [2:0]            w_nb;
   logic [32:0]           w_end;
   logic                  w_oob;

   logic                  r_v1;
   logic                  r_par;
   logic [OFW-1:0]        r_off;
   logic [1:0]            r_size;
   logic                  r_oob1;

   logic [DATA_WIDTH-1:0]   w_lo;
   logic [DATA_WIDTH-1:0]   w_hi;
   logic [2*DATA_WIDTH-1:0] w_pair;
   logic [7:0]              w_sh;
   logic [31:0]             w_top;
   logic [31:0]             w_algn;
   logic [31:0]             w_d1;
   logic                    w_o1;

   logic [31:0] r_len;
   logic [31:0] w_wr_len;
   logic [31:0] w_len_base;

   // Word w sits in the bank of its parity; w+1 in the other bank.
   // For odd w the even-bank index moves up one and wraps at the top.
   assign w_word    = bus.rd_addr[BAW-1:OFW];
   assign w_off     = bus.rd_addr[OFW-1:0];
   assign w_half    = w_word[ADDR_WIDTH-1:1];
   assign w_ev_addr = w_word[0] ? w_half + HW'(1) : w_half;
   assign w_wr_half = bus.wr_addr[ADDR_WIDTH-1:1];

   // Byte count of the requested load; zero for the illegal size
   always_comb begin
      w_nb = 3'd0;
      unique case (bus.rd_size)
         2'b00:   w_nb = 3'd1;
         2'b01:   w_nb = 3'd2;
         2'b10:   w_nb = 3'd4;
         default: w_nb = 3'd0;
      endcase
   end

   // Bounds use the length as registered before this issue edge
   assign w_end = 33'(bus.rd_addr) + 33'(w_nb);
   assign w_oob = (bus.rd_size == 2'b11)
                | (w_end > {1'b0, r_len})
                | (w_end > TOP);

   // Bank writes; reads in the same block return the old word
   always_ff @(posedge clk) begin
      if (bus.wr_en && !bus.wr_addr[0]) r_even[w_wr_half] <= bus.wr_data;
      if (bus.wr_en &&  bus.wr_addr[0]) r_odd[w_wr_half]  <= bus.wr_data;
      if (bus.rd_en) begin
         r_ev_q <= r_even[w_ev_addr];
         r_od_q <= r_odd[w_half];
      end
   end

   // Issue stage: load attributes travel alongside the bank reads
   always_ff @(posedge clk) begin
      if (rst) r_v1 <= 1'b0;
      else     r_v1 <= bus.rd_en;
      if (bus.rd_en) begin
         r_par  <= w_word[0];
         r_off  <= w_off;
         r_size <= bus.rd_size;
         r_oob1 <= w_oob;
      end
   end

   // Order the two words as a byte stream and pick four bytes at the offset
   assign w_lo   = r_par ? r_od_q : r_ev_q;
   assign w_hi   = r_par ? r_ev_q : r_od_q;
   assign w_pair = {w_lo, w_hi};
   assign w_sh   = 8'(2 * DATA_WIDTH - 32) - 8'({r_off, 3'b000});
   assign w_top  = 32'(w_pair >> w_sh);

   // Right-justify the first nbytes of the picked four
   always_comb begin
      w_algn = w_top;
      unique case (r_size)
         2'b00:   w_algn = {24'd0, w_top[31:24]};
         2'b01:   w_algn = {16'd0, w_top[31:16]};
         default: w_algn = w_top;
      endcase
   end

   assign w_d1 = (r_v1 && !r_oob1) ? w_algn : 32'd0;
   assign w_o1 = r_v1 && r_oob1;

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic        r_v2;
         logic [31:0] r_d2;
         logic        r_o2;
         // Optional register stage after alignment
         always_ff @(posedge clk) begin
            if (rst) begin
               r_v2 <= 1'b0;
               r_d2 <= 32'd0;
               r_o2 <= 1'b0;
            end else begin
               r_v2 <= r_v1;
               r_d2 <= w_d1;
               r_o2 <= w_o1;
            end
         end
         assign bus.rd_valid = r_v2;
         assign bus.rd_data  = r_d2;
         assign bus.rd_oob   = r_o2;
      end else begin : g_comb
         assign bus.rd_valid = r_v1;
         assign bus.rd_data  = w_d1;
         assign bus.rd_oob   = w_o1;
      end
   endgenerate

   // A write extends the packet to the end of its word
   assign w_wr_len   = (32'(bus.wr_addr) + 32'd1) << OFW;
   assign w_len_base = bus.len_clr ? 32'd0 : r_len;

   // Length tracking; a write alongside len_clr starts the new packet
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len <= 32'd0;
      end else if (bus.wr_en) begin
         r_len <= (w_wr_len > w_len_base) ? w_wr_len : w_len_base;
      end else if (bus.len_clr) begin
         r_len <= 32'd0;
      end
   end

   assign bus.len = r_len;
endmodule

// File: tb/tb_packet_ram_bytewise.sv
// Bench for packet_ram_bytewise: a 32-bit/no-outreg instance and a
// 64-bit/outreg instance checked against a byte-array reference.
module tb_packet_ram_bytewise;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   int   cyc;

   packet_ram_bytewise_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) ifa ();
   packet_ram_bytewise_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(64)) ifb ();

   packet_ram_bytewise #(
      .ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REG(0)
   ) u_a (
      .clk(clk), .rst(rst), .bus(ifa.slave)
   );

   packet_ram_bytewise #(
      .ADDR_WIDTH(4), .DATA_WIDTH(64), .OUT_REG(1)
   ) u_b (
      .clk(clk), .rst(rst), .bus(ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [31:0] d;
      logic        o;
   } exp_t;

   logic [7:0] ma [4096];
   logic [7:0] mb [128];
   int         len_a;
   int         len_b;
   exp_t       qa [$];
   exp_t       qb [$];

   function automatic logic [32:0] ld_ref(input int addr, input logic [1:0] sz,
                                          input int ln, input int total,
                                          input logic [31:0] b4);
      int nb;
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
      if (sz == 2'b11 || addr + nb > ln || addr + nb > total)
         return {1'b1, 32'd0};
      return {1'b0, b4 >> (8 * (4 - nb))};
   endfunction

   always @(posedge clk) begin : model
      logic [31:0] b4;
      logic [32:0] r;
      int          a;
      int          wl;
      cyc = cyc + 1;
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         if (ifa.rd_en) begin
            a = int'(ifa.rd_addr);
            for (int k = 0; k < 4; k++) b4[31-8*k -: 8] = ma[(a + k) % 4096];
            r = ld_ref(a, ifa.rd_size, len_a, 4096, b4);
            qa.push_back('{due: cyc, d: r[31:0], o: r[32]});
         end
         if (ifb.rd_en) begin
            a = int'(ifb.rd_addr);
            for (int k = 0; k < 4; k++) b4[31-8*k -: 8] = mb[(a + k) % 128];
            r = ld_ref(a, ifb.rd_size, len_b, 128, b4);
            qb.push_back('{due: cyc + 1, d: r[31:0], o: r[32]});
         end
      end
      if (ifa.wr_en) begin
         a = int'(ifa.wr_addr);
         for (int k = 0; k < 4; k++) ma[a*4 + k] = ifa.wr_data[31-8*k -: 8];
      end
      if (ifb.wr_en) begin
         a = int'(ifb.wr_addr);
         for (int k = 0; k < 8; k++) mb[a*8 + k] = ifb.wr_data[63-8*k -: 8];
      end
      if (rst) len_a = 0;
      else if (ifa.wr_en) begin
         wl = (int'(ifa.wr_addr) + 1) * 4;
         if (ifa.len_clr) len_a = 0;
         if (wl > len_a) len_a = wl;
      end else if (ifa.len_clr) len_a = 0;
      if (rst) len_b = 0;
      else if (ifb.wr_en) begin
         wl = (int'(ifb.wr_addr) + 1) * 8;
         if (ifb.len_clr) len_b = 0;
         if (wl > len_b) len_b = wl;
      end else if (ifb.len_clr) len_b = 0;
   end

   // Compare process: outputs are stable at the falling edge
   always @(negedge clk) begin : compare
      logic ev;
      if (cyc >= 1) begin
         ev = (qa.size() > 0) && (qa[0].due == cyc);
         chk("a_valid", 32'(ifa.rd_valid), 32'(ev));
         if (ev) begin
            chk("a_data", ifa.rd_data, qa[0].d);
            chk("a_oob", 32'(ifa.rd_oob), 32'(qa[0].o));
            void'(qa.pop_front());
         end
         chk("a_len", ifa.len, 32'(len_a));
         ev = (qb.size() > 0) && (qb[0].due == cyc);
         chk("b_valid", 32'(ifb.rd_valid), 32'(ev));
         if (ev) begin
            chk("b_data", ifb.rd_data, qb[0].d);
            chk("b_oob", 32'(ifb.rd_oob), 32'(qb[0].o));
            void'(qb.pop_front());
         end
         chk("b_len", ifb.len, 32'(len_b));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic a_load(input string nm, input int addr, input logic [1:0] sz,
                         input logic [31:0] ed, input logic eo);
      ifa.rd_en   = 1'b1;
      ifa.rd_addr = 12'(addr);
      ifa.rd_size = sz;
      @(negedge clk);
      ifa.rd_en = 1'b0;
      chk({nm, "_v"}, 32'(ifa.rd_valid), 32'd1);
      chk({nm, "_d"}, ifa.rd_data, ed);
      chk({nm, "_o"}, 32'(ifa.rd_oob), 32'(eo));
   endtask

   task automatic a_write(input int wa, input logic [31:0] wd, input logic clr);
      ifa.wr_en   = 1'b1;
      ifa.wr_addr = 10'(wa);
      ifa.wr_data = wd;
      ifa.len_clr = clr;
      @(negedge clk);
      ifa.wr_en   = 1'b0;
      ifa.len_clr = 1'b0;
   endtask

   task automatic b_load(input string nm, input int addr, input logic [1:0] sz,
                         input logic [31:0] ed, input logic eo);
      ifb.rd_en   = 1'b1;
      ifb.rd_addr = 7'(addr);
      ifb.rd_size = sz;
      @(negedge clk);
      ifb.rd_en = 1'b0;
      chk({nm, "_lat1"}, 32'(ifb.rd_valid), 32'd0);
      @(negedge clk);
      chk({nm, "_v"}, 32'(ifb.rd_valid), 32'd1);
      chk({nm, "_d"}, ifb.rd_data, ed);
      chk({nm, "_o"}, 32'(ifb.rd_oob), 32'(eo));
   endtask

   logic [31:0] wa_tab [4];
   logic [31:0] bb_tab [4];
   logic [63:0] wb;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      cyc    = 0;
      len_a  = 0;
      len_b  = 0;
      wa_tab = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
      rst = 1'b1;
      ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.len_clr = 1'b0;
      ifa.rd_en = 1'b0; ifa.rd_addr = '0; ifa.rd_size = '0;
      ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.len_clr = 1'b0;
      ifb.rd_en = 1'b0; ifb.rd_addr = '0; ifb.rd_size = '0;
      repeat (3) @(negedge clk);
      chk("rst_a_valid", 32'(ifa.rd_valid), 32'd0);
      chk("rst_a_data", ifa.rd_data, 32'd0);
      chk("rst_a_len", ifa.len, 32'd0);
      chk("rst_b_valid", 32'(ifb.rd_valid), 32'd0);
      chk("rst_b_data", ifb.rd_data, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) a_write(i, wa_tab[i], 1'b0);
      chk("a_len16", ifa.len, 32'd16);
      a_load("w0", 0, 2'b10, 32'h00112233, 1'b0);
      a_load("w3", 3, 2'b10, 32'h33445566, 1'b0);
      a_load("h7", 7, 2'b01, 32'h00007788, 1'b0);
      a_load("b13", 13, 2'b00, 32'h000000DD, 1'b0);
      a_load("w13", 13, 2'b10, 32'h0, 1'b1);
      a_load("w12", 12, 2'b10, 32'hCCDDEEFF, 1'b0);
      a_load("ill", 0, 2'b11, 32'h0, 1'b1);

      ifa.wr_en = 1'b1; ifa.wr_addr = 10'd1; ifa.wr_data = 32'hDEADBEEF;
      a_load("rdfirst", 4, 2'b10, 32'h44556677, 1'b0);
      ifa.wr_en = 1'b0;
      a_load("newdata", 4, 2'b10, 32'hDEADBEEF, 1'b0);

      bb_tab = '{32'h00112233, 32'hDEADBEEF, 32'h8899AABB, 32'hCCDDEEFF};
      for (int i = 0; i < 4; i++) begin
         ifa.rd_en   = 1'b1;
         ifa.rd_addr = 12'(4 * i);
         ifa.rd_size = 2'b10;
         @(negedge clk);
         chk("b2b_v", 32'(ifa.rd_valid), 32'd1);
         chk("b2b_d", ifa.rd_data, bb_tab[i]);
      end
      ifa.rd_en = 1'b0;
      @(negedge clk);
      chk("b2b_idle", 32'(ifa.rd_valid), 32'd0);

      a_write(0, 32'h00112233, 1'b1);
      chk("len_clr_w0", ifa.len, 32'd4);
      a_write(2, 32'h8899AABB, 1'b0);
      chk("len_w2", ifa.len, 32'd12);
      a_write(1, 32'h44556677, 1'b0);
      chk("len_w1", ifa.len, 32'd12);
      a_load("in12", 8, 2'b10, 32'h8899AABB, 1'b0);
      ifa.len_clr = 1'b1;
      @(negedge clk);
      ifa.len_clr = 1'b0;
      chk("len_clr", ifa.len, 32'd0);
      a_load("oob_b0", 0, 2'b00, 32'h0, 1'b1);
      a_load("oob_w4", 4, 2'b10, 32'h0, 1'b1);

      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 8; k++) wb[63-8*k -: 8] = 8'(8 * i + k);
         ifb.wr_en   = 1'b1;
         ifb.wr_addr = 4'(i);
         ifb.wr_data = wb;
         @(negedge clk);
      end
      ifb.wr_en = 1'b0;
      chk("b_len128", ifb.len, 32'd128);
      b_load("bw6", 6, 2'b10, 32'h06070809, 1'b0);
      b_load("bwrap", 126, 2'b10, 32'h0, 1'b1);
      b_load("bw125", 125, 2'b10, 32'h0, 1'b1);
      b_load("bh126", 126, 2'b01, 32'h00007E7F, 1'b0);
      b_load("bb127", 127, 2'b00, 32'h0000007F, 1'b0);

      ifb.rd_en   = 1'b1;
      ifb.rd_addr = 7'd0;
      ifb.rd_size = 2'b10;
      @(negedge clk);
      ifb.rd_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_fl_v", 32'(ifb.rd_valid), 32'd0);
      chk("rst_fl_d", ifb.rd_data, 32'd0);
      chk("rst_fl_o", 32'(ifb.rd_oob), 32'd0);
      chk("rst_fl_len", ifb.len, 32'd0);
      @(negedge clk);
      chk("rst_fl_v2", 32'(ifb.rd_valid), 32'd0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
